// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the core's single external memory port between the instruction-fetch
// requester and the MEM-stage data requester. Data requests win over fetches,
// but the fetch side wins once data has taken MAX_D_STREAK grants in a row
// while a fetch was waiting.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   if_req_i / if_addr_i     fetch request and address
//   if_busy_o / if_done_o    fetch stall, one-cycle completion pulse
//   if_rdata_o               fetched word, valid with if_done_o
//   d_req_i, d_we_i, d_addr_i, d_wdata_i, d_sel_i
//                            data request, direction, address, write data, byte mask
//   d_busy_o / d_done_o      data stall, one-cycle completion pulse
//   d_rdata_o                load data, valid with d_done_o
//   mem_rwe_o                {write, read} command to memory, never both set
//   mem_addr_o, mem_sel_o, mem_wdata_o
//                            command fields, held constant while a command is open
//   mem_rdata_i, mem_busy_i, mem_done_i
//                            memory read data, not-ready flag, completion pulse
//   dbg_state_o, dbg_streak_o
//                            arbiter state and current data streak, for observation
//
// Handshake: a requester raises req with its fields and keeps it high until its
// done pulses; done is a single-cycle pulse and rdata is valid in that cycle and
// held afterwards. A req seen in the same cycle as its own done is ignored, so a
// requester that keeps req high gets a fresh transaction, never a repeat of the
// one just finished. Toward memory, a command is issued when mem_rwe_o becomes
// non-zero; it and its fields stay fixed until mem_done_i, and a new command is
// only issued while mem_busy_i is low.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              if_req_i,
    input  logic [ADDR_W-1:0]                 if_addr_i,
    output logic                              if_busy_o,
    output logic                              if_done_o,
    output logic [DATA_W-1:0]                 if_rdata_o,
    input  logic                              d_req_i,
    input  logic                              d_we_i,
    input  logic [ADDR_W-1:0]                 d_addr_i,
    input  logic [DATA_W-1:0]                 d_wdata_i,
    input  logic [3:0]                        d_sel_i,
    output logic                              d_busy_o,
    output logic                              d_done_o,
    output logic [DATA_W-1:0]                 d_rdata_o,
    output logic [1:0]                        mem_rwe_o,
    output logic [ADDR_W-1:0]                 mem_addr_o,
    output logic [3:0]                        mem_sel_o,
    output logic [DATA_W-1:0]                 mem_wdata_o,
    input  logic [DATA_W-1:0]                 mem_rdata_i,
    input  logic                              mem_busy_i,
    input  logic                              mem_done_i,
    output logic [1:0]                        dbg_state_o,
    output logic [$clog2(MAX_D_STREAK+1)-1:0] dbg_streak_o
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SW-1:0]       r_streak;
    logic                r_if_done;
    logic                r_d_done;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic [1:0]          r_mem_rwe;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [3:0]          r_mem_sel;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic                w_if_live;
    logic                w_d_live;
    logic                w_streak_max;
    logic                w_grant_i;
    logic                w_grant_d;
    logic                w_done_i;
    logic                w_done_d;

    // A request is only eligible when its own done is not pulsing this cycle.
    assign w_if_live    = if_req_i & ~r_if_done;
    assign w_d_live     = d_req_i  & ~r_d_done;
    assign w_streak_max = (r_streak == SW'(MAX_D_STREAK));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_done_i    = 1'b0;
        w_done_d    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!mem_busy_i) begin
                    // Data wins unless it has used up its streak while a fetch waits.
                    if (w_d_live && !(w_streak_max && w_if_live)) begin
                        w_grant_d   = 1'b1;
                        w_state_nxt = ST_SERVE_D;
                    end else if (w_if_live) begin
                        w_grant_i   = 1'b1;
                        w_state_nxt = ST_SERVE_I;
                    end
                end
            end
            ST_SERVE_I: begin
                if (mem_done_i) begin
                    w_done_i    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SERVE_D: begin
                if (mem_done_i) begin
                    w_done_d    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_streak    <= '0;
            r_if_done   <= 1'b0;
            r_d_done    <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_mem_rwe   <= 2'b00;
            r_mem_addr  <= '0;
            r_mem_sel   <= 4'h0;
            r_mem_wdata <= '0;
        end else begin
            r_if_done <= w_done_i;
            r_d_done  <= w_done_d;
            if (w_done_i) begin
                r_if_rdata <= mem_rdata_i;
            end
            if (w_done_d) begin
                r_d_rdata <= mem_rdata_i;
            end
            if (w_done_i || w_done_d) begin
                r_mem_rwe <= 2'b00;
            end
            if (w_grant_d) begin
                r_mem_rwe   <= d_we_i ? 2'b10 : 2'b01;
                r_mem_addr  <= d_addr_i;
                r_mem_sel   <= d_we_i ? d_sel_i : 4'h0;
                r_mem_wdata <= d_wdata_i;
                // The streak only counts data grants that made a fetch wait.
                if (w_if_live) begin
                    r_streak <= w_streak_max ? r_streak : r_streak + SW'(1);
                end else begin
                    r_streak <= '0;
                end
            end
            if (w_grant_i) begin
                r_mem_rwe   <= 2'b01;
                r_mem_addr  <= if_addr_i;
                r_mem_sel   <= 4'h0;
                r_mem_wdata <= '0;
                r_streak    <= '0;
            end
        end
    end

    assign if_busy_o    = if_req_i & ~r_if_done;
    assign d_busy_o     = d_req_i  & ~r_d_done;
    assign if_done_o    = r_if_done;
    assign d_done_o     = r_d_done;
    assign if_rdata_o   = r_if_rdata;
    assign d_rdata_o    = r_d_rdata;
    assign mem_rwe_o    = r_mem_rwe;
    assign mem_addr_o   = r_mem_addr;
    assign mem_sel_o    = r_mem_sel;
    assign mem_wdata_o  = r_mem_wdata;
    assign dbg_state_o  = r_state;
    assign dbg_streak_o = r_streak;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MAX = 4;
  localparam int SW  = $clog2(MAX + 1);

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_busy_o, if_done_o;
  logic [DW-1:0] if_rdata_o;
  logic          d_req_i, d_we_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic [3:0]    d_sel_i;
  logic          d_busy_o, d_done_o;
  logic [DW-1:0] d_rdata_o;
  logic [1:0]    mem_rwe_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0]    mem_sel_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_busy_i, mem_done_i;
  logic [1:0]    dbg_state_o;
  logic [SW-1:0] dbg_streak_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_busy_o(if_busy_o),
    .if_done_o(if_done_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_sel_i(d_sel_i), .d_busy_o(d_busy_o),
    .d_done_o(d_done_o), .d_rdata_o(d_rdata_o),
    .mem_rwe_o(mem_rwe_o), .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_busy_i(mem_busy_i), .mem_done_i(mem_done_i),
    .dbg_state_o(dbg_state_o), .dbg_streak_o(dbg_streak_o)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_i    = 1'b0;
    if_addr_i   = '0;
    d_req_i     = 1'b0;
    d_we_i      = 1'b0;
    d_addr_i    = '0;
    d_wdata_i   = '0;
    d_sel_i     = 4'h0;
    mem_rdata_i = '0;
    mem_busy_i  = 1'b0;
    mem_done_i  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    next_cycle();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        ir, dr, mb, md;
    logic [31:0] rd;
    logic        e_ibusy;
    logic [1:0]  e_rwe;
    logic [31:0] e_addr;
    logic        e_idone, e_ddone;
    logic [31:0] e_irdata, e_drdata;
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic dr, input logic mb, input logic md,
                              input logic [31:0] rd, input logic e_ibusy, input logic [1:0] e_rwe,
                              input logic [31:0] e_addr, input logic e_idone, input logic e_ddone,
                              input logic [31:0] e_irdata, input logic [31:0] e_drdata);
    vec_t v;
    v.ir = ir; v.dr = dr; v.mb = mb; v.md = md; v.rd = rd;
    v.e_ibusy = e_ibusy; v.e_rwe = e_rwe; v.e_addr = e_addr;
    v.e_idone = e_idone; v.e_ddone = e_ddone;
    v.e_irdata = e_irdata; v.e_drdata = e_drdata;
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  // Owner: 0 = port free, 1 = fetch transaction open, 2 = data transaction open.
  int          m_owner;
  int          m_streak;
  logic [1:0]  m_rwe;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
  logic [3:0]  m_sel;
  logic        m_idone, m_ddone;

  task automatic model_reset();
    m_owner = 0; m_streak = 0; m_rwe = 2'b00; m_addr = '0; m_wdata = '0;
    m_sel = 4'h0; m_irdata = '0; m_drdata = '0; m_idone = 1'b0; m_ddone = 1'b0;
  endtask

  // Advances the model across one rising edge using the inputs now applied.
  task automatic model_step();
    bit  i_want, d_want, idone_n, ddone_n;
    idone_n = 1'b0;
    ddone_n = 1'b0;
    i_want  = if_req_i && !m_idone;
    d_want  = d_req_i  && !m_ddone;
    if (m_owner == 0) begin
      if (!mem_busy_i) begin
        if (d_want && !(m_streak == MAX && i_want)) begin
          m_owner  = 2;
          m_rwe    = d_we_i ? 2'b10 : 2'b01;
          m_addr   = d_addr_i;
          m_sel    = d_we_i ? d_sel_i : 4'h0;
          m_wdata  = d_wdata_i;
          m_streak = i_want ? ((m_streak < MAX) ? m_streak + 1 : MAX) : 0;
        end else if (i_want) begin
          m_owner  = 1;
          m_rwe    = 2'b01;
          m_addr   = if_addr_i;
          m_sel    = 4'h0;
          m_streak = 0;
        end
      end
    end else if (mem_done_i) begin
      if (m_owner == 1) begin
        m_irdata = mem_rdata_i;
        idone_n  = 1'b1;
      end else begin
        m_drdata = mem_rdata_i;
        ddone_n  = 1'b1;
      end
      m_rwe   = 2'b00;
      m_owner = 0;
    end
    m_idone = idone_n;
    m_ddone = ddone_n;
  endtask

  // ---------------- test sequence ----------------
  vec_t        tbl[13];
  logic [1:0]  prev_rwe;
  bit          got_i[6];
  int          got_streak[6];
  int          grants;
  bit          exp_i[6];
  int          exp_streak[6];
  bit          mem_active;
  int          mem_lat;

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();

    // Reset values, checked while reset is still held.
    rst = 1'b0;
    if_req_i = 1'b1;
    #3;
    chk("rst_rwe",    64'(mem_rwe_o), 64'(2'b00));
    chk("rst_addr",   64'(mem_addr_o), 64'h0);
    chk("rst_sel",    64'(mem_sel_o), 64'h0);
    chk("rst_wdata",  64'(mem_wdata_o), 64'h0);
    chk("rst_idone",  64'(if_done_o), 64'h0);
    chk("rst_ddone",  64'(d_done_o), 64'h0);
    chk("rst_irdata", 64'(if_rdata_o), 64'h0);
    chk("rst_drdata", 64'(d_rdata_o), 64'h0);
    chk("rst_state",  64'(dbg_state_o), 64'h0);
    chk("rst_streak", 64'(dbg_streak_o), 64'h0);
    chk("rst_ibusy",  64'(if_busy_o), 64'h1);
    chk("rst_dbusy",  64'(d_busy_o), 64'h0);
    do_reset();

    // Table: fetch only, simultaneous fetch+data, spurious done, req dropped before grant.
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 2'b01, 32'h100,  1'b0, 1'b0, 32'h0,  32'h0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 2'b01, 32'h100,  1'b0, 1'b0, 32'h0,  32'h0);
    tbl[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 2'b01, 32'h100,  1'b0, 1'b0, 32'h0,  32'h0);
    tbl[3]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h13, 1'b1, 2'b00, 32'h100,  1'b1, 1'b0, 32'h13, 32'h0);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 2'b00, 32'h100,  1'b0, 1'b0, 32'h13, 32'h0);
    tbl[5]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 2'b01, 32'h2004, 1'b0, 1'b0, 32'h13, 32'h0);
    tbl[6]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 32'hAA, 1'b1, 2'b00, 32'h2004, 1'b0, 1'b1, 32'h13, 32'hAA);
    tbl[7]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 2'b01, 32'h100,  1'b0, 1'b0, 32'h13, 32'hAA);
    tbl[8]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h55, 1'b1, 2'b00, 32'h100,  1'b1, 1'b0, 32'h55, 32'hAA);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 2'b00, 32'h100,  1'b0, 1'b0, 32'h55, 32'hAA);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h77, 1'b0, 2'b00, 32'h100,  1'b0, 1'b0, 32'h55, 32'hAA);
    tbl[11] = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 2'b00, 32'h100,  1'b0, 1'b0, 32'h55, 32'hAA);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 2'b00, 32'h100,  1'b0, 1'b0, 32'h55, 32'hAA);

    if_addr_i = 32'h100;
    d_addr_i  = 32'h2004;
    d_we_i    = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if_req_i    = tbl[i].ir;
      d_req_i     = tbl[i].dr;
      mem_busy_i  = tbl[i].mb;
      mem_done_i  = tbl[i].md;
      mem_rdata_i = tbl[i].rd;
      #1;
      chk($sformatf("tbl%0d_ibusy", i), 64'(if_busy_o), 64'(tbl[i].e_ibusy));
      next_cycle();
      chk($sformatf("tbl%0d_rwe", i),    64'(mem_rwe_o), 64'(tbl[i].e_rwe));
      chk($sformatf("tbl%0d_addr", i),   64'(mem_addr_o), 64'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_idone", i),  64'(if_done_o), 64'(tbl[i].e_idone));
      chk($sformatf("tbl%0d_ddone", i),  64'(d_done_o), 64'(tbl[i].e_ddone));
      chk($sformatf("tbl%0d_irdata", i), 64'(if_rdata_o), 64'(tbl[i].e_irdata));
      chk($sformatf("tbl%0d_drdata", i), 64'(d_rdata_o), 64'(tbl[i].e_drdata));
    end
    idle_inputs();
    next_cycle();

    // Data write: all command fields stable until done, single done pulse.
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h2004;
    d_wdata_i = 32'hDEADBEEF; d_sel_i = 4'hF;
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      chk("wr_rwe",   64'(mem_rwe_o), 64'(2'b10));
      chk("wr_addr",  64'(mem_addr_o), 64'h2004);
      chk("wr_wdata", 64'(mem_wdata_o), 64'hDEADBEEF);
      chk("wr_sel",   64'(mem_sel_o), 64'hF);
      chk("wr_ddone_early", 64'(d_done_o), 64'h0);
      if (c == 3) mem_done_i = 1'b1;
      next_cycle();
    end
    chk("wr_ddone", 64'(d_done_o), 64'h1);
    chk("wr_idone", 64'(if_done_o), 64'h0);
    chk("wr_rwe_clr", 64'(mem_rwe_o), 64'h0);
    d_req_i = 1'b0; mem_done_i = 1'b0;
    next_cycle();
    chk("wr_ddone_once", 64'(d_done_o), 64'h0);
    idle_inputs();
    next_cycle();

    // Starvation: data keeps requesting; memory is busy for one cycle after each completion.
    if_addr_i = 32'h100; if_req_i = 1'b1;
    d_addr_i = 32'h3000; d_we_i = 1'b0; d_req_i = 1'b1;
    prev_rwe = 2'b00; grants = 0;
    for (int k = 0; k < 6; k++) begin got_i[k] = 1'b0; got_streak[k] = -1; end
    for (int cyc = 0; cyc < 200 && grants < 6; cyc++) begin
      next_cycle();
      if (if_done_o) if_req_i = 1'b0;
      if (mem_rwe_o != 2'b00 && prev_rwe == 2'b00) begin
        got_i[grants]      = (mem_addr_o == 32'h100);
        got_streak[grants] = int'(dbg_streak_o);
        grants++;
      end
      prev_rwe   = mem_rwe_o;
      mem_busy_i = mem_done_i;
      mem_done_i = (mem_rwe_o != 2'b00);
    end
    exp_i      = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_streak = '{1, 2, 3, 4, 0, 0};
    chk("starve_grants", 64'(grants), 64'd6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("starve_g%0d_is_fetch", k), 64'(got_i[k]), 64'(exp_i[k]));
      chk($sformatf("starve_g%0d_streak", k), 64'(got_streak[k]), 64'(exp_streak[k]));
    end
    d_req_i = 1'b0;
    next_cycle();
    idle_inputs();
    repeat (3) next_cycle();

    // mem_busy_i high for 5 cycles blocks the command; it issues right after.
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h4000; mem_busy_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      chk("busy_no_cmd", 64'(mem_rwe_o), 64'h0);
    end
    mem_busy_i = 1'b0;
    next_cycle();
    chk("busy_cmd_rwe", 64'(mem_rwe_o), 64'(2'b01));
    chk("busy_cmd_addr", 64'(mem_addr_o), 64'h4000);
    chk("busy_dbusy", 64'(d_busy_o), 64'h1);
    mem_done_i = 1'b1; mem_rdata_i = 32'h1234;
    next_cycle();
    chk("busy_ddone", 64'(d_done_o), 64'h1);
    chk("busy_drdata", 64'(d_rdata_o), 64'h1234);
    chk("busy_dbusy_done", 64'(d_busy_o), 64'h0);
    idle_inputs();
    next_cycle();

    // Reset in the middle of a data transaction.
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h5000; d_wdata_i = 32'hCAFEF00D; d_sel_i = 4'h3;
    repeat (2) next_cycle();
    chk("mid_state", 64'(dbg_state_o), 64'h2);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rwe",    64'(mem_rwe_o), 64'h0);
    chk("mid_addr",   64'(mem_addr_o), 64'h0);
    chk("mid_sel",    64'(mem_sel_o), 64'h0);
    chk("mid_wdata",  64'(mem_wdata_o), 64'h0);
    chk("mid_drdata", 64'(d_rdata_o), 64'h0);
    chk("mid_irdata", 64'(if_rdata_o), 64'h0);
    chk("mid_state0", 64'(dbg_state_o), 64'h0);
    idle_inputs();
    next_cycle();
    chk("mid_no_done", 64'(d_done_o), 64'h0);
    rst = 1'b1;
    next_cycle();
    if_req_i = 1'b1; if_addr_i = 32'h180;
    next_cycle();
    chk("post_rst_rwe", 64'(mem_rwe_o), 64'(2'b01));
    chk("post_rst_addr", 64'(mem_addr_o), 64'h180);
    next_cycle();
    mem_done_i = 1'b1; mem_rdata_i = 32'h00A00093;
    next_cycle();
    chk("post_rst_idone", 64'(if_done_o), 64'h1);
    chk("post_rst_irdata", 64'(if_rdata_o), 64'h00A00093);
    idle_inputs();
    next_cycle();

    // Randomised traffic against the reference model.
    do_reset();
    model_reset();
    mem_active = 1'b0;
    mem_lat = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_rwe",    64'(mem_rwe_o), 64'(m_rwe));
      chk("rnd_idone",  64'(if_done_o), 64'(m_idone));
      chk("rnd_ddone",  64'(d_done_o), 64'(m_ddone));
      chk("rnd_irdata", 64'(if_rdata_o), 64'(m_irdata));
      chk("rnd_drdata", 64'(d_rdata_o), 64'(m_drdata));
      chk("rnd_streak", 64'(dbg_streak_o), 64'(m_streak));
      if (m_rwe != 2'b00) begin
        chk("rnd_addr", 64'(mem_addr_o), 64'(m_addr));
        chk("rnd_sel",  64'(mem_sel_o), 64'(m_sel));
        if (m_rwe == 2'b10) chk("rnd_wdata", 64'(mem_wdata_o), 64'(m_wdata));
      end

      // Fetch requester.
      if (if_req_i && m_idone) begin
        if_req_i = ($urandom_range(0, 3) == 0);
        if_addr_i = {$urandom_range(0, 255), 2'b00};
      end else if (if_req_i && $urandom_range(0, 29) == 0) begin
        if_req_i = 1'b0;
      end else if (!if_req_i && $urandom_range(0, 2) == 0) begin
        if_req_i = 1'b1;
        if_addr_i = {$urandom_range(0, 255), 2'b00};
      end
      // Data requester.
      if (d_req_i && m_ddone) begin
        d_req_i = ($urandom_range(0, 3) == 0);
      end else if (d_req_i && $urandom_range(0, 29) == 0) begin
        d_req_i = 1'b0;
      end else if (!d_req_i && $urandom_range(0, 1) == 0) begin
        d_req_i   = 1'b1;
        d_we_i    = $urandom_range(0, 1) == 1;
        d_addr_i  = {$urandom_range(0, 65535), 2'b00};
        d_wdata_i = $urandom;
        d_sel_i   = 4'($urandom_range(1, 15));
      end
      // Memory.
      mem_busy_i  = ($urandom_range(0, 3) == 0);
      mem_done_i  = 1'b0;
      mem_rdata_i = $urandom;
      if (m_rwe != 2'b00 && !mem_active) begin
        mem_active = 1'b1;
        mem_lat = $urandom_range(0, 3);
      end
      if (mem_active) begin
        if (mem_lat == 0) begin
          mem_done_i = 1'b1;
          mem_active = 1'b0;
        end else begin
          mem_lat--;
        end
      end else if ($urandom_range(0, 19) == 0) begin
        mem_done_i = 1'b1;
      end
      #1;
      chk("rnd_ibusy", 64'(if_busy_o), 64'(if_req_i & ~m_idone));
      chk("rnd_dbusy", 64'(d_busy_o), 64'(d_req_i & ~m_ddone));
      model_step();
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the CPU core's single external memory port between the instruction-fetch requester and the MEM-stage data requester, replacing their direct, conflicting drive of the memory address and data bus. Each requester gets a private request/done handshake. The block serialises their transactions onto one memory channel with data-over-instruction priority and a bounded anti-starvation rule. It sits between `inst_fetch`/`stage_mem` and the top-level `mem_*` pins of `riscv_cpu`.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_D_STREAK`, 4, maximum consecutive data grants while a fetch is pending (≥1)

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `if_req_i`  in  1  fetch request, held until `if_done_o`
- `if_addr_i`  in  ADDR_W  fetch address
- `if_busy_o`  out  1  fetch stall: `if_req_i & ~if_done_o`
- `if_done_o`  out  1  one-cycle fetch completion pulse
- `if_rdata_o`  out  DATA_W  fetched word, valid with `if_done_o`
- `d_req_i`  in  1  data request, held until `d_done_o`
- `d_we_i`  in  1  1 = write, 0 = read
- `d_addr_i`  in  ADDR_W  data address
- `d_wdata_i`  in  DATA_W  write data
- `d_sel_i`  in  4  byte-write mask
- `d_busy_o`  out  1  data stall: `d_req_i & ~d_done_o`
- `d_done_o`  out  1  one-cycle data completion pulse
- `d_rdata_o`  out  DATA_W  load data, valid with `d_done_o`
- `mem_rwe_o`  out  2  bit1 = write, bit0 = read; never both set
- `mem_addr_o`  out  ADDR_W  memory address
- `mem_sel_o`  out  4  byte mask (0 on reads)
- `mem_wdata_o`  out  DATA_W  write data
- `mem_rdata_i`  in  DATA_W  read data, valid with `mem_done_i`
- `mem_busy_i`  in  1  memory cannot accept a new command
- `mem_done_i`  in  1  one-cycle completion of the outstanding command

## Operation
- States: IDLE, SERVE_I, SERVE_D.
- IDLE arbitration, evaluated only when `mem_busy_i` = 0:
  - Data wins if `d_req_i`, unless `streak == MAX_D_STREAK` and `if_req_i`; in that case fetch wins.
  - Fetch wins if only `if_req_i` is high.
  - With no request, or with `mem_busy_i` = 1, stay in IDLE.
- On a grant, register the winner's addr/we/wdata/sel into the `mem_*` outputs and enter SERVE_I or SERVE_D.
- SERVE_x: hold `mem_rwe_o`/`mem_addr_o`/`mem_sel_o`/`mem_wdata_o` constant until `mem_done_i`.
  - On `mem_done_i`: capture `mem_rdata_i` into the winner's rdata register, pulse the winner's done next cycle, clear `mem_rwe_o`, and return to IDLE.
- `streak` counter, width clog2(MAX_D_STREAK+1):
  - Data grant with `if_req_i` high: increment, saturating.
  - Fetch grant, or any grant with `if_req_i` low: clear.
- Requester dropping req mid-transaction (e.g. branch flush): the transaction still completes and done still pulses; the requester discards it.
- A req that drops before its grant produces no memory traffic.
- Arbitration ignores a req in the same cycle its done pulses. This prevents a double issue.
- rdata outputs hold their last value between done pulses.
- `mem_done_i` in IDLE is ignored.

## Timing
- Reset values (asynchronous, `rst` = 0):
  - State IDLE, `streak` = 0.
  - `mem_rwe_o` = 0, `mem_addr_o` = 0, `mem_sel_o` = 0, `mem_wdata_o` = 0.
  - `if_done_o` = `d_done_o` = 0; both rdata outputs = 0.
  - Busy outputs follow their combinational equations.
- Reset mid-transaction abandons the command immediately; no done pulse is issued.
- Req seen in IDLE at cycle 0 → `mem_rwe_o` asserted in cycle 1.
- `mem_done_i` at cycle k → requester done pulse and rdata at cycle k+1, state IDLE at k+1.
- Earliest next command: cycle k+2.
- Minimum transaction latency, req to done: 2 cycles plus the memory latency.

## Test plan
- Fetch only: `if_addr_i`=0x100, memory done 3 cycles after the command with rdata 0x00000013 → `mem_rwe_o`=01 at cycle 1; `if_done_o` pulses with `if_rdata_o`=0x13; `d_done_o` stays 0.
- Data write: `d_we_i`=1, addr 0x2004, wdata 0xDEADBEEF, sel 0xF → `mem_rwe_o`=10 with all fields stable until done; `d_done_o` pulses once.
- Simultaneous fetch and data requests → data served first, then fetch; `mem_addr_o` sequence is data addr then fetch addr; `if_busy_o` stays high throughout.
- Starvation, MAX_D_STREAK=4, both requesters continuously requesting with data re-requesting each time → grant order D,D,D,D,I,D…; `streak` returns to 0 after the I grant.
- `mem_busy_i` held high for 5 cycles with `d_req_i` high → no `mem_rwe_o` during those cycles; command issues the cycle after `mem_busy_i` falls.
- Reset asserted during SERVE_D → all outputs take reset values asynchronously; after release, a fresh fetch request completes normally.
